// File: rtl/prga_check_if.sv
// rtl/prga_check_if.sv - handshake and S/CT/PT memory bus of the PRGA check stage
interface prga_check_if;
    logic       en;
    logic       rdy;
    logic       pt_valid;
    logic [7:0] s_addr;
    logic [7:0] s_rddata;
    logic [7:0] s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr;
    logic [7:0] ct_rddata;
    logic [7:0] pt_addr;
    logic [7:0] pt_wrdata;
    logic       pt_wren;

    modport master (
        input  en, s_rddata, ct_rddata,
        output rdy, pt_valid, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
    );

    modport slave (
        output en, s_rddata, ct_rddata,
        input  rdy, pt_valid, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
    );
endinterface

// File: rtl/prga_check.sv
// rtl/prga_check.sv - ARC4 PRGA decrypt of length-prefixed CT into PT with printable-byte early abort
module prga_check #(
    parameter bit         CHECK_EN = 1'b1,
    parameter logic [7:0] LO_CHAR  = 8'h20,
    parameter logic [7:0] HI_CHAR  = 8'h7E
) (
    input  logic          clk,
    input  logic          rst_n,
    prga_check_if.master  bus
);
    typedef enum logic [3:0] {
        IDLE, RD_LEN, GET_LEN, WR_LEN, RD_SI, GET_SI, RD_SJ, GET_SJ,
        WR_I, WR_J, RD_PAD, GET_PAD, WR_PT, DONE
    } state_t;

    state_t     state;
    logic       rdy, pt_valid, s_wren, pt_wren;
    logic [7:0] s_addr, s_wrdata, ct_addr, pt_addr, pt_wrdata;
    logic [7:0] len, i, j, k, si, sj, ctk;

    assign bus.rdy       = rdy;
    assign bus.pt_valid  = pt_valid;
    assign bus.s_addr    = s_addr;
    assign bus.s_wrdata  = s_wrdata;
    assign bus.s_wren    = s_wren;
    assign bus.ct_addr   = ct_addr;
    assign bus.pt_addr   = pt_addr;
    assign bus.pt_wrdata = pt_wrdata;
    assign bus.pt_wren   = pt_wren;

    // Outputs are registered on entry to the state that owns them, so each
    // address is on the bus for the whole cycle named after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rdy       <= 1'b1;
            pt_valid  <= 1'b0;
            s_wren    <= 1'b0;
            pt_wren   <= 1'b0;
            s_addr    <= 8'd0;
            s_wrdata  <= 8'd0;
            ct_addr   <= 8'd0;
            pt_addr   <= 8'd0;
            pt_wrdata <= 8'd0;
            len       <= 8'd0;
            i         <= 8'd0;
            j         <= 8'd0;
            k         <= 8'd0;
            si        <= 8'd0;
            sj        <= 8'd0;
            ctk       <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        rdy      <= 1'b0;
                        pt_valid <= 1'b0;
                        ct_addr  <= 8'd0;
                        i        <= 8'd0;
                        j        <= 8'd0;
                        k        <= 8'd0;
                        state    <= RD_LEN;
                    end
                end
                RD_LEN: state <= GET_LEN;
                GET_LEN: begin
                    len       <= bus.ct_rddata;
                    pt_addr   <= 8'd0;
                    pt_wrdata <= bus.ct_rddata;
                    pt_wren   <= 1'b1;
                    state     <= WR_LEN;
                end
                WR_LEN: begin
                    pt_wren <= 1'b0;
                    k       <= 8'd1;
                    i       <= 8'd1;
                    if (len == 8'd0) begin
                        pt_valid <= 1'b1;
                        state    <= DONE;
                    end else begin
                        s_addr  <= 8'd1;
                        ct_addr <= 8'd1;
                        state   <= RD_SI;
                    end
                end
                RD_SI: state <= GET_SI;
                GET_SI: begin
                    si     <= bus.s_rddata;
                    ctk    <= bus.ct_rddata;
                    j      <= j + bus.s_rddata;
                    s_addr <= j + bus.s_rddata;
                    state  <= RD_SJ;
                end
                RD_SJ: state <= GET_SJ;
                GET_SJ: begin
                    sj       <= bus.s_rddata;
                    s_addr   <= i;
                    s_wrdata <= bus.s_rddata;
                    s_wren   <= 1'b1;
                    state    <= WR_I;
                end
                WR_I: begin
                    s_addr   <= j;
                    s_wrdata <= si;
                    state    <= WR_J;
                end
                WR_J: begin
                    s_wren <= 1'b0;
                    s_addr <= si + sj;
                    state  <= RD_PAD;
                end
                RD_PAD: state <= GET_PAD;
                GET_PAD: begin
                    pt_addr   <= k;
                    pt_wrdata <= bus.s_rddata ^ ctk;
                    pt_wren   <= 1'b1;
                    state     <= WR_PT;
                end
                WR_PT: begin
                    pt_wren <= 1'b0;
                    if (CHECK_EN && (pt_wrdata < LO_CHAR || pt_wrdata > HI_CHAR)) begin
                        pt_valid <= 1'b0;
                        state    <= DONE;
                    end else if (k == len) begin
                        pt_valid <= 1'b1;
                        state    <= DONE;
                    end else begin
                        k       <= k + 8'd1;
                        i       <= i + 8'd1;
                        s_addr  <= i + 8'd1;
                        ct_addr <= k + 8'd1;
                        state   <= RD_SI;
                    end
                end
                DONE: begin
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prga_check.sv
// tb/tb_prga_check.sv - scoreboard bench for prga_check with S/CT/PT memory models
module tb_prga_check;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prga_check_if b0 ();
    prga_check_if b1 ();

    prga_check #(.CHECK_EN(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.master));
    prga_check #(.CHECK_EN(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.master));

    logic sel = 1'b0;
    logic en  = 1'b0;
    assign b0.en = en & ~sel;
    assign b1.en = en & sel;

    logic [7:0] s_mem [256];
    logic [7:0] ct_mem [256];
    logic [7:0] pt_mem [256];
    logic [7:0] s_rd = 8'd0;
    logic [7:0] ct_rd = 8'd0;
    assign b0.s_rddata  = s_rd;
    assign b1.s_rddata  = s_rd;
    assign b0.ct_rddata = ct_rd;
    assign b1.ct_rddata = ct_rd;

    wire [7:0] m_s_addr    = sel ? b1.s_addr    : b0.s_addr;
    wire [7:0] m_s_wrdata  = sel ? b1.s_wrdata  : b0.s_wrdata;
    wire       m_s_wren    = sel ? b1.s_wren    : b0.s_wren;
    wire [7:0] m_ct_addr   = sel ? b1.ct_addr   : b0.ct_addr;
    wire [7:0] m_pt_addr   = sel ? b1.pt_addr   : b0.pt_addr;
    wire [7:0] m_pt_wrdata = sel ? b1.pt_wrdata : b0.pt_wrdata;
    wire       m_pt_wren   = sel ? b1.pt_wren   : b0.pt_wren;
    wire       m_rdy       = sel ? b1.rdy       : b0.rdy;
    wire       m_pt_valid  = sel ? b1.pt_valid  : b0.pt_valid;

    always @(posedge clk) begin
        s_rd  <= s_mem[m_s_addr];
        ct_rd <= ct_mem[m_ct_addr];
        if (m_s_wren)  s_mem[m_s_addr]   <= m_s_wrdata;
        if (m_pt_wren) pt_mem[m_pt_addr] <= m_pt_wrdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         done;
        logic [7:0] addr;
        logic [7:0] data;
        int         at;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;
    bit prev_rdy = 1'b1;
    bit s_wren_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every PT write and every rdy rise is matched against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_rdy = 1'b1;
        end else begin
            if (m_s_wren) s_wren_seen = 1'b1;
            if (m_pt_wren) begin
                if (q.size() == 0 || q[0].done) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected pt write: got addr %0h data %0h", m_pt_addr, m_pt_wrdata);
                end else begin
                    e = q.pop_front();
                    check("pt_addr", m_pt_addr, e.addr);
                    check("pt_wrdata", m_pt_wrdata, e.data);
                end
            end
            if (m_rdy && !prev_rdy) begin
                if (q.size() == 0 || !q[0].done) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected completion: got pt_valid %0d", m_pt_valid);
                end else begin
                    e = q.pop_front();
                    check("pt_valid", m_pt_valid, e.data);
                    check("rdy latency", cyc, e.at);
                end
            end
            prev_rdy = m_rdy;
        end
    end

    task automatic load(input logic [7:0] c0, c1, c2, c3);
        for (int n = 0; n < 256; n++) begin
            s_mem[n]  = n[7:0];
            ct_mem[n] = 8'h00;
            pt_mem[n] = 8'hAA;
        end
        ct_mem[0] = c0; ct_mem[1] = c1; ct_mem[2] = c2; ct_mem[3] = c3;
    endtask

    task automatic start(input bit hold, output int t);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        check("rdy drop after accept", m_rdy, 1'b0);
        if (!hold) en = 1'b0;
    endtask

    task automatic push_w(input logic [7:0] a, input logic [7:0] d);
        q.push_back('{done: 1'b0, addr: a, data: d, at: 0});
    endtask

    task automatic push_d(input logic v, input int at);
        q.push_back('{done: 1'b1, addr: 8'h00, data: {7'd0, v}, at: at});
    endtask

    task automatic push_hi(input int t);
        push_w(8'd0, 8'h03); push_w(8'd1, 8'h48); push_w(8'd2, 8'h69); push_w(8'd3, 8'h21);
        push_d(1'b1, t + 31);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((q.size() != 0 || !m_rdy) && n < 400) begin
            @(posedge clk);
            n++;
        end
        check({name, " scoreboard drained"}, q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int t;
        int cnt;
        load(8'h03, 8'h4A, 8'h6C, 8'h26);
        repeat (3) @(posedge clk);
        #1;
        check("reset rdy", b0.rdy, 1'b1);
        check("reset pt_valid", b0.pt_valid, 1'b0);
        check("reset s_wren", b0.s_wren, 1'b0);
        check("reset pt_wren", b0.pt_wren, 1'b0);
        check("reset addrs", {b0.s_addr, b0.ct_addr, b0.pt_addr}, 24'd0);
        check("reset wrdata", {b0.s_wrdata, b0.pt_wrdata}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // "Hi!" decrypts cleanly
        load(8'h03, 8'h4A, 8'h6C, 8'h26);
        start(1'b0, t);
        push_hi(t);
        wait_done("hi");

        // first byte decrypts to 00: abort after one WR_PT
        load(8'h03, 8'h02, 8'h6C, 8'h26);
        start(1'b0, t);
        push_w(8'd0, 8'h03); push_w(8'd1, 8'h00); push_d(1'b0, t + 13);
        wait_done("abort");
        check("abort pt[2] untouched", pt_mem[2], 8'hAA);
        check("abort pt[3] untouched", pt_mem[3], 8'hAA);

        // same ciphertext without checking
        sel = 1'b1;
        load(8'h03, 8'h02, 8'h6C, 8'h26);
        start(1'b0, t);
        push_w(8'd0, 8'h03); push_w(8'd1, 8'h00); push_w(8'd2, 8'h69); push_w(8'd3, 8'h21);
        push_d(1'b1, t + 31);
        wait_done("nocheck");
        sel = 1'b0;

        // empty message
        load(8'h00, 8'h4A, 8'h6C, 8'h26);
        s_wren_seen = 1'b0;
        start(1'b0, t);
        push_w(8'd0, 8'h00); push_d(1'b1, t + 4);
        wait_done("empty");
        check("empty no s_wren", s_wren_seen, 1'b0);

        // en held high: one run, then a second accept only once rdy is back
        load(8'h03, 8'h4A, 8'h6C, 8'h26);
        start(1'b1, t);
        push_hi(t);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!m_rdy && cnt < 100);
        check("held en first run ends", m_rdy, 1'b1);
        for (int n = 0; n < 256; n++) s_mem[n] = n[7:0];
        @(posedge clk);
        #1;
        t = cyc;
        check("held en second accept", m_rdy, 1'b0);
        en = 1'b0;
        push_hi(t);
        wait_done("held en");

        // reset during WR_I of byte 2
        load(8'h03, 8'h4A, 8'h6C, 8'h26);
        start(1'b0, t);
        push_w(8'd0, 8'h03); push_w(8'd1, 8'h48);
        cnt = 0;
        for (int n = 0; n < 100 && cnt < 3; n++) begin
            @(negedge clk);
            if (m_s_wren) cnt++;
        end
        rst_n = 1'b0;
        #1;
        check("midrun reset rdy", b0.rdy, 1'b1);
        check("midrun reset pt_valid", b0.pt_valid, 1'b0);
        check("midrun reset strobes", {b0.s_wren, b0.pt_wren}, 2'b00);
        @(posedge clk);
        #1;
        check("midrun reset strobes next cycle", {b0.s_wren, b0.pt_wren}, 2'b00);
        check("midrun writes before reset", q.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        load(8'h03, 8'h4A, 8'h6C, 8'h26);
        start(1'b0, t);
        push_hi(t);
        wait_done("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
